// File: rtl/key_conditioner.sv
// Four-key debouncer: per-key synchronizer, debounce FSM, hold timer and
// registered press/release/hold pulses gated by enable.
module key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 240000,
  parameter int unsigned HOLD_CYCLES     = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_n,
  input  logic       enable,
  output logic [3:0] key_level,
  output logic [3:0] key_press,
  output logic [3:0] key_release,
  output logic [3:0] key_hold,
  output logic       any_press
);

  localparam int unsigned NKEYS = 4;
  localparam logic [17:0] DB_LAST   = 18'(DEBOUNCE_CYCLES - 1);
  localparam logic [23:0] HOLD_LAST = 24'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } key_state_t;

  logic [3:0]  sync1;
  logic [3:0]  sync2;
  logic [3:0]  pressed;

  key_state_t  state_q    [NKEYS];
  key_state_t  state_d    [NKEYS];
  logic [17:0] db_cnt_q   [NKEYS];
  logic [17:0] db_cnt_d   [NKEYS];
  logic [23:0] hold_cnt_q [NKEYS];
  logic [23:0] hold_cnt_d [NKEYS];
  logic [3:0]  hold_done_q;
  logic [3:0]  hold_done_d;

  logic [3:0]  level_d;
  logic [3:0]  press_ev;
  logic [3:0]  release_ev;
  logic [3:0]  hold_ev;
  logic [3:0]  gate;

  assign pressed = ~sync2;
  assign gate    = {NKEYS{enable}};

  always_comb begin
    state_d     = state_q;
    db_cnt_d    = db_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    hold_done_d = hold_done_q;
    level_d     = key_level;
    press_ev    = '0;
    release_ev  = '0;
    hold_ev     = '0;
    for (int unsigned i = 0; i < NKEYS; i++) begin
      unique case (state_q[i])
        RELEASED: begin
          if (pressed[i]) begin
            state_d[i]  = PRESS_WAIT;
            db_cnt_d[i] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed[i]) begin
            state_d[i]  = RELEASED;
            db_cnt_d[i] = '0;
          end else if (db_cnt_q[i] == DB_LAST) begin
            state_d[i]     = PRESSED;
            level_d[i]     = 1'b1;
            press_ev[i]    = 1'b1;
            hold_cnt_d[i]  = '0;
            hold_done_d[i] = 1'b0;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 18'd1;
          end
        end
        PRESSED: begin
          if (!pressed[i]) begin
            state_d[i]  = RELEASE_WAIT;
            db_cnt_d[i] = '0;
          end else if (hold_cnt_q[i] != HOLD_LAST) begin
            hold_cnt_d[i] = hold_cnt_q[i] + 24'd1;
          end else if (!hold_done_q[i]) begin
            // hold_done survives bounces so a press yields one hold pulse
            hold_ev[i]     = 1'b1;
            hold_done_d[i] = 1'b1;
          end
        end
        RELEASE_WAIT: begin
          if (pressed[i]) begin
            state_d[i]  = PRESSED;
            db_cnt_d[i] = '0;
          end else if (db_cnt_q[i] == DB_LAST) begin
            state_d[i]    = RELEASED;
            level_d[i]    = 1'b0;
            release_ev[i] = 1'b1;
          end else begin
            db_cnt_d[i] = db_cnt_q[i] + 18'd1;
          end
        end
        default: begin
          state_d[i]  = RELEASED;
          db_cnt_d[i] = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1       <= '1;
      sync2       <= '1;
      hold_done_q <= '0;
      key_level   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_hold    <= '0;
      any_press   <= 1'b0;
      for (int unsigned i = 0; i < NKEYS; i++) begin
        state_q[i]    <= RELEASED;
        db_cnt_q[i]   <= '0;
        hold_cnt_q[i] <= '0;
      end
    end else begin
      sync1       <= key_n;
      sync2       <= sync1;
      hold_done_q <= hold_done_d;
      key_level   <= level_d;
      key_press   <= press_ev & gate;
      key_release <= release_ev & gate;
      key_hold    <= hold_ev & gate;
      any_press   <= |(press_ev & gate);
      for (int unsigned i = 0; i < NKEYS; i++) begin
        state_q[i]    <= state_d[i];
        db_cnt_q[i]   <= db_cnt_d[i];
        hold_cnt_q[i] <= hold_cnt_d[i];
      end
    end
  end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 240000 (20 ms at 12 MHz), stable-sample count required to accept a level change; legal range 2..262143.
REQ-002 Parameter HOLD_CYCLES, default 12000000 (1 s at 12 MHz), debounced-pressed duration before a hold pulse; legal range 2..16777215.
REQ-003 clk  input  1  system clock, 12 MHz; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 key_n  input  4  raw board keys, asynchronous, active-low (0 = pressed).
REQ-006 enable  input  1  pulse gate; 0 suppresses key_press, key_release and key_hold, while key_level keeps tracking.
REQ-007 key_level  output  4  debounced key state, active-high (1 = pressed), registered.
REQ-008 key_press  output  4  one-cycle pulse per accepted press, registered.
REQ-009 key_release  output  4  one-cycle pulse per accepted release, registered.
REQ-010 key_hold  output  4  one-cycle pulse when a key stays pressed for HOLD_CYCLES, registered.
REQ-011 any_press  output  1  registered OR of the four key_press bits, aligned with key_press.

Function
REQ-012 Each key_n bit SHALL pass through its own two-flop synchronizer; the FSM uses only the second-flop output, pressed = inverted value.
REQ-013 Each key has an independent FSM with states RELEASED, PRESS_WAIT, PRESSED and RELEASE_WAIT, plus an 18-bit debounce counter and a 24-bit hold counter.
REQ-014 RELEASED: a synchronized pressed sample moves the FSM to PRESS_WAIT and clears the debounce counter; otherwise it stays.
REQ-015 PRESS_WAIT: a released sample returns the FSM to RELEASED and clears the counter (glitch rejected, no pulse); otherwise the counter increments.
REQ-016 PRESS_WAIT with counter == DEBOUNCE_CYCLES-1 and a pressed sample: the FSM moves to PRESSED, key_level goes to 1, key_press pulses, and the hold counter clears.
REQ-017 Press latency: with edge 0 as the first edge that samples key_n low, and key_n held low, key_level and key_press become 1 after edge DEBOUNCE_CYCLES+2; key_press returns to 0 after the next edge.
REQ-018 PRESSED: the hold counter increments and saturates. When it reaches HOLD_CYCLES-1, key_hold pulses exactly once per press.
REQ-019 PRESSED: a released sample moves the FSM to RELEASE_WAIT and clears the debounce counter; the hold counter freezes.
REQ-020 RELEASE_WAIT mirrors PRESS_WAIT. A pressed sample returns the FSM to PRESSED with key_level still 1, no pulses, and no further key_hold for that press.
REQ-021 RELEASE_WAIT at counter == DEBOUNCE_CYCLES-1 with a released sample moves the FSM to RELEASED, sets key_level to 0, and pulses key_release, with latency symmetric to REQ-017.
REQ-022 All pulse outputs are 0 on any cycle where no qualifying transition occurs; no pulse is ever longer than one cycle.
REQ-023 The four keys are fully independent. Simultaneous accepted events on several keys SHALL pulse all corresponding bits in the same cycle.
REQ-024 A pulse event whose cycle has enable == 0 is dropped, not deferred; FSM and counters advance identically regardless of enable.
REQ-025 Counter arithmetic is unsigned. The debounce counter never exceeds DEBOUNCE_CYCLES-1; the hold counter saturates at HOLD_CYCLES-1 with no wrap.

Reset
REQ-026 While rst is 1 at a rising edge: synchronizer flops SHALL load 1 (released), FSMs go to RELEASED, counters go to 0, and every output is 0.
REQ-027 Reset asserted mid-debounce or mid-hold discards progress. A key still held after reset deasserts SHALL repeat the full REQ-017 sequence before key_press pulses.
REQ-028 The first edge after rst deasserts performs a normal sample; no pulses are generated by reset itself.

Verification (bench with DEBOUNCE_CYCLES=4, HOLD_CYCLES=10)
REQ-029 key_n[0] driven low at edge 0 and held -> key_level[0]=1 and a one-cycle key_press[0]=1, any_press=1 after edge 6; other bits stay 0.
REQ-030 key_n[1] low for 3 cycles, then high -> no key_press[1]; key_level[1] stays 0; FSM back in RELEASED.
REQ-031 key_n[2] pressed and held 20 cycles past acceptance -> exactly one key_hold[2] pulse, 10 cycles after key_press[2]. Release -> key_release[2] pulses 6 edges after key_n goes high.
REQ-032 key_n[3:0] all driven low at the same edge -> key_press=4'b1111 in a single cycle. Repeat with enable=0 -> key_level=4'b1111, key_press stays 0.
REQ-033 Key held, rst pulsed for 1 cycle at debounce count 2, then key still held -> outputs 0 during reset; key_press pulses 6 edges after the first post-reset edge.
REQ-034 Pressed key bounces high for 2 cycles -> key_level stays 1; no key_release, key_press or second key_hold.
